// File: rtl/nv_nvdla_sdp_rdma_rd_arb_pkg.sv
// Shared widths and defaults for the SDP RDMA read arbiter slice.
package nv_nvdla_sdp_rdma_rd_arb_pkg;
  localparam int REQ_W        = 47;
  localparam int RSP_W        = 65;
  localparam int SIZE_MSB     = 46;
  localparam int SIZE_LSB     = 32;
  localparam int SIZE_W       = SIZE_MSB - SIZE_LSB + 1;
  localparam int NUM_REQ_DEF  = 4;
  localparam int ID_DEPTH_DEF = 16;

  typedef logic [SIZE_W-1:0] size_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nv_nvdla_sdp_rdma_rd_arb_if.sv
// Engine-side and dmaif-side handshake bundle of the read arbiter.
interface nv_nvdla_sdp_rdma_rd_arb_if
  import nv_nvdla_sdp_rdma_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ-1:0]       req_rdy;
  logic [NUM_REQ*REQ_W-1:0] req_pd;
  logic                     dma_rd_req_vld;
  logic                     dma_rd_req_rdy;
  logic [REQ_W-1:0]         dma_rd_req_pd;
  logic                     dma_rd_rsp_vld;
  logic                     dma_rd_rsp_rdy;
  logic [RSP_W-1:0]         dma_rd_rsp_pd;
  logic [NUM_REQ-1:0]       rsp_vld;
  logic [NUM_REQ-1:0]       rsp_rdy;
  logic [RSP_W-1:0]         rsp_pd;

  // slave: the arbiter; master: engines plus dmaif around it
  modport slave (
    input  req_vld, req_pd, dma_rd_req_rdy, dma_rd_rsp_vld, dma_rd_rsp_pd, rsp_rdy,
    output req_rdy, dma_rd_req_vld, dma_rd_req_pd, dma_rd_rsp_rdy, rsp_vld, rsp_pd
  );
  modport master (
    output req_vld, req_pd, dma_rd_req_rdy, dma_rd_rsp_vld, dma_rd_rsp_pd, rsp_rdy,
    input  req_rdy, dma_rd_req_vld, dma_rd_req_pd, dma_rd_rsp_rdy, rsp_vld, rsp_pd
  );
endinterface

// File: rtl/nv_nvdla_sdp_rdma_rd_arb_idfifo.sv
// Flop-based sync FIFO holding {engine id, size} of outstanding reads; flags registered.
module nv_nvdla_sdp_rdma_rd_arb_idfifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q, do_push, do_pop;

  assign do_push  = push_i & ~full_q;
  assign do_pop   = pop_i & ~empty_q;
  assign wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == DEPTH_C);
      empty_q  <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/nv_nvdla_sdp_rdma_rd_arb.sv
// Round-robin arbiter sharing one SDP DMA read channel among NUM_REQ engines;
// an in-order ID FIFO steers each response beat back to its issuing engine.
module nv_nvdla_sdp_rdma_rd_arb
  import nv_nvdla_sdp_rdma_rd_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_DEPTH = ID_DEPTH_DEF
) (
  input  logic                             nvdla_core_clk,
  input  logic                             nvdla_core_rstn,
  nv_nvdla_sdp_rdma_rd_arb_if.slave        arb_if,
  output logic                             arb_idle,
  output logic                             arb_err
);
  localparam int IDW   = id_w(NUM_REQ);
  localparam int ENT_W = IDW + SIZE_W;
  localparam logic [IDW:0] NREQ_L = (IDW+1)'(NUM_REQ);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d;
  logic [IDW-1:0] rr_grant, grant, hid;
  logic [IDW:0]   rr_sum;
  logic           rr_found;
  logic           locked_q, locked_d, arb_err_q, arb_err_d;
  size_t          beat_cnt_q, beat_cnt_d, hsize;
  logic           any_vld, id_full, id_empty, req_acc, rsp_acc, rsp_last;
  logic [ENT_W-1:0] head_ent;

  assign any_vld = |arb_if.req_vld;

  // First valid engine at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    rr_grant = rr_ptr_q;
    rr_found = 1'b0;
    rr_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (rr_sum >= NREQ_L) rr_sum = rr_sum - NREQ_L;
      if (!rr_found && arb_if.req_vld[rr_sum[IDW-1:0]]) begin
        rr_grant = rr_sum[IDW-1:0];
        rr_found = 1'b1;
      end
    end
  end

  assign grant = locked_q ? lock_id_q : rr_grant;

  always_comb begin
    arb_if.dma_rd_req_pd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) arb_if.dma_rd_req_pd = arb_if.req_pd[i*REQ_W +: REQ_W];
    end
  end

  assign arb_if.dma_rd_req_vld = any_vld & ~id_full;
  assign req_acc = arb_if.dma_rd_req_vld & arb_if.dma_rd_req_rdy;

  always_comb begin
    arb_if.req_rdy        = '0;
    arb_if.req_rdy[grant] = arb_if.dma_rd_req_vld & arb_if.dma_rd_req_rdy;
  end

  // A stalled request pins the grant so the presented payload cannot change
  always_comb begin
    locked_d  = locked_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (req_acc) begin
      locked_d = 1'b0;
      rr_ptr_d = (grant == IDW'(NUM_REQ-1)) ? '0 : grant + IDW'(1);
    end else if (arb_if.dma_rd_req_vld) begin
      locked_d  = 1'b1;
      lock_id_d = grant;
    end
  end

  nv_nvdla_sdp_rdma_rd_arb_idfifo #(
    .WIDTH (ENT_W),
    .DEPTH (ID_DEPTH)
  ) u_idfifo (
    .clk_i   (nvdla_core_clk),
    .rst_ni  (nvdla_core_rstn),
    .push_i  (req_acc),
    .wdata_i ({grant, arb_if.dma_rd_req_pd[SIZE_MSB:SIZE_LSB]}),
    .pop_i   (rsp_last),
    .rdata_o (head_ent),
    .full_o  (id_full),
    .empty_o (id_empty)
  );

  assign hid   = head_ent[ENT_W-1 -: IDW];
  assign hsize = head_ent[SIZE_W-1:0];

  always_comb begin
    arb_if.rsp_vld      = '0;
    arb_if.rsp_vld[hid] = arb_if.dma_rd_rsp_vld & ~id_empty;
  end

  assign arb_if.dma_rd_rsp_rdy = arb_if.rsp_rdy[hid] & ~id_empty;
  assign arb_if.rsp_pd         = arb_if.dma_rd_rsp_pd;

  assign rsp_acc    = arb_if.dma_rd_rsp_vld & arb_if.dma_rd_rsp_rdy;
  assign rsp_last   = rsp_acc & (beat_cnt_q == hsize);
  assign beat_cnt_d = rsp_last ? '0 : (rsp_acc ? beat_cnt_q + SIZE_W'(1) : beat_cnt_q);
  // A beat with nothing outstanding has no owner: flag it permanently
  assign arb_err_d  = arb_err_q | (arb_if.dma_rd_rsp_vld & id_empty);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      locked_q   <= 1'b0;
      beat_cnt_q <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      locked_q   <= locked_d;
      beat_cnt_q <= beat_cnt_d;
      arb_err_q  <= arb_err_d;
    end
  end

  assign arb_idle = id_empty & ~any_vld;
  assign arb_err  = arb_err_q;
endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_rd_arb.sv
// Scoreboard bench for the SDP RDMA read arbiter: directed vectors, queue-based monitor.
module tb_nv_nvdla_sdp_rdma_rd_arb;
  import nv_nvdla_sdp_rdma_rd_arb_pkg::*;

  localparam int NR = 4;

  typedef struct packed {
    logic [REQ_W-1:0] pd;
    logic [NR-1:0]    oh;
  } req_exp_t;

  typedef struct packed {
    logic [RSP_W-1:0] pd;
    logic [NR-1:0]    oh;
  } rsp_exp_t;

  logic clk, rstn, arb_idle, arb_err;
  int   checks = 0;
  int   errors = 0;
  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  req_exp_t mon_req;
  rsp_exp_t mon_rsp;

  nv_nvdla_sdp_rdma_rd_arb_if #(.NUM_REQ(NR)) bus ();

  nv_nvdla_sdp_rdma_rd_arb #(.NUM_REQ(NR), .ID_DEPTH(16)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .arb_if          (bus),
    .arb_idle        (arb_idle),
    .arb_err         (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mkpd(input int eng, input int size, input int tag);
    logic [31:0] addr;
    addr = 32'hA000_0000 + 32'(eng * 256) + 32'(tag);
    return {15'(size), addr};
  endfunction

  task automatic set_pd(input int eng, input logic [REQ_W-1:0] pd);
    bus.req_pd[eng*REQ_W +: REQ_W] = pd;
  endtask

  task automatic push_req(input int eng, input logic [REQ_W-1:0] pd);
    req_q.push_back('{pd: pd, oh: NR'(1) << eng});
  endtask

  task automatic push_rsp(input int eng, input int val);
    rsp_q.push_back('{pd: RSP_W'(val), oh: NR'(1) << eng});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted transfer on either side must match the head of its queue
  always @(negedge clk) begin
    if (rstn && bus.dma_rd_req_vld && bus.dma_rd_req_rdy) begin
      if (req_q.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        mon_req = req_q.pop_front();
        chk("req_pd", bus.dma_rd_req_pd, mon_req.pd);
        chk("req_rdy", bus.req_rdy, mon_req.oh);
      end
    end
    if (rstn && bus.dma_rd_rsp_vld && bus.dma_rd_rsp_rdy) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        mon_rsp = rsp_q.pop_front();
        chk("rsp_vld", bus.rsp_vld, mon_rsp.oh);
        chk("rsp_pd", bus.rsp_pd, mon_rsp.pd);
      end
    end
  end

  initial begin
    rstn = 1'b0;
    bus.req_vld = '0;
    bus.req_pd = '0;
    bus.dma_rd_req_rdy = 1'b1;
    bus.dma_rd_rsp_vld = 1'b0;
    bus.dma_rd_rsp_pd = '0;
    bus.rsp_rdy = '1;
    repeat (2) @(negedge clk);
    chk("reset_req_rdy", bus.req_rdy, 0);
    chk("reset_rsp_vld", bus.rsp_vld, 0);
    chk("reset_dma_req_vld", bus.dma_rd_req_vld, 0);
    chk("reset_dma_rsp_rdy", bus.dma_rd_rsp_rdy, 0);
    chk("reset_idle", arb_idle, 1);
    chk("reset_err", arb_err, 0);
    tick();
    rstn = 1'b1;

    // Fairness: all engines valid, grants 0,1,2,3,0,1,2,3
    for (int k = 0; k < NR; k++) set_pd(k, mkpd(k, 0, 1));
    for (int n = 0; n < 8; n++) push_req(n % NR, mkpd(n % NR, 0, 1));
    bus.req_vld = '1;
    repeat (8) tick();
    bus.req_vld = '0;
    for (int n = 0; n < 8; n++) push_rsp(n % NR, 100 + n);
    for (int n = 0; n < 8; n++) begin
      bus.dma_rd_rsp_vld = 1'b1;
      bus.dma_rd_rsp_pd = RSP_W'(100 + n);
      tick();
    end
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge clk);
    chk("s1_idle", arb_idle, 1);

    // Stall lock: engine 2 stalled five cycles while engine 0 raises valid
    tick();
    set_pd(2, mkpd(2, 0, 2));
    set_pd(0, mkpd(0, 0, 2));
    bus.dma_rd_req_rdy = 1'b0;
    bus.req_vld = 4'b0100;
    @(negedge clk);
    chk("s2_pd_first", bus.dma_rd_req_pd, mkpd(2, 0, 2));
    tick();
    bus.req_vld = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("s2_pd_hold", bus.dma_rd_req_pd, mkpd(2, 0, 2));
      chk("s2_vld_hold", bus.dma_rd_req_vld, 1);
      chk("s2_rdy0_low", bus.req_rdy[0], 0);
      tick();
    end
    push_req(2, mkpd(2, 0, 2));
    push_req(0, mkpd(0, 0, 2));
    bus.dma_rd_req_rdy = 1'b1;
    tick();
    bus.req_vld = 4'b0001;
    tick();
    bus.req_vld = '0;
    push_rsp(2, 200);
    push_rsp(0, 201);
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd = RSP_W'(200);
    tick();
    bus.dma_rd_rsp_pd = RSP_W'(201);
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge clk);
    chk("s2_idle", arb_idle, 1);

    // ID FIFO full: 16 outstanding, then one burst frees a slot
    tick();
    set_pd(3, mkpd(3, 0, 3));
    for (int n = 0; n < 16; n++) push_req(3, mkpd(3, 0, 3));
    bus.req_vld = 4'b1000;
    repeat (16) tick();
    @(negedge clk);
    chk("s3_full_vld", bus.dma_rd_req_vld, 0);
    chk("s3_full_rdy", bus.req_rdy, 0);
    chk("s3_full_idle", arb_idle, 0);
    tick();
    push_rsp(3, 300);
    push_req(3, mkpd(3, 0, 3));
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd = RSP_W'(300);
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge clk);
    chk("s3_freed_vld", bus.dma_rd_req_vld, 1);
    tick();
    bus.req_vld = '0;
    for (int n = 0; n < 16; n++) push_rsp(3, 301 + n);
    for (int n = 0; n < 16; n++) begin
      bus.dma_rd_rsp_vld = 1'b1;
      bus.dma_rd_rsp_pd = RSP_W'(301 + n);
      tick();
    end
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge clk);
    chk("s3_idle", arb_idle, 1);

    // Multi-beat: engine 1 size 3 with a backpressured beat, then engine 0 size 0
    tick();
    set_pd(1, mkpd(1, 3, 4));
    set_pd(0, mkpd(0, 0, 4));
    push_req(1, mkpd(1, 3, 4));
    push_req(0, mkpd(0, 0, 4));
    bus.req_vld = 4'b0010;
    tick();
    bus.req_vld = 4'b0001;
    tick();
    bus.req_vld = '0;
    for (int n = 0; n < 4; n++) push_rsp(1, 400 + n);
    push_rsp(0, 404);
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd = RSP_W'(400);
    tick();
    bus.dma_rd_rsp_pd = RSP_W'(401);
    tick();
    bus.dma_rd_rsp_pd = RSP_W'(402);
    bus.rsp_rdy = 4'b1101;
    @(negedge clk);
    chk("s4_stall_rdy", bus.dma_rd_rsp_rdy, 0);
    chk("s4_stall_vld", bus.rsp_vld, 4'b0010);
    tick();
    bus.rsp_rdy = '1;
    tick();
    bus.dma_rd_rsp_pd = RSP_W'(403);
    tick();
    bus.dma_rd_rsp_pd = RSP_W'(404);
    @(negedge clk);
    chk("s4_eng0_vld", bus.rsp_vld, 4'b0001);
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge clk);
    chk("s4_idle", arb_idle, 1);
    chk("s4_rsp_vld_off", bus.rsp_vld, 0);

    // Orphan response beat sets the sticky error
    tick();
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd = RSP_W'(500);
    @(negedge clk);
    chk("s5_rdy", bus.dma_rd_rsp_rdy, 0);
    chk("s5_rsp_vld", bus.rsp_vld, 0);
    chk("s5_err_pre", arb_err, 0);
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge clk);
    chk("s5_err", arb_err, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("s5_err_sticky", arb_err, 1);

    // Reset in the middle of a 4-beat burst after two beats
    tick();
    set_pd(2, mkpd(2, 3, 6));
    push_req(2, mkpd(2, 3, 6));
    bus.req_vld = 4'b0100;
    tick();
    bus.req_vld = '0;
    push_rsp(2, 600);
    push_rsp(2, 601);
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd = RSP_W'(600);
    tick();
    bus.dma_rd_rsp_pd = RSP_W'(601);
    tick();
    bus.dma_rd_rsp_pd = RSP_W'(602);
    rstn = 1'b0;
    @(negedge clk);
    chk("s6_req_rdy", bus.req_rdy, 0);
    chk("s6_rsp_vld", bus.rsp_vld, 0);
    chk("s6_dma_req_vld", bus.dma_rd_req_vld, 0);
    chk("s6_dma_rsp_rdy", bus.dma_rd_rsp_rdy, 0);
    chk("s6_idle", arb_idle, 1);
    chk("s6_err", arb_err, 0);
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    rstn = 1'b1;
    tick();
    set_pd(1, mkpd(1, 0, 7));
    push_req(1, mkpd(1, 0, 7));
    bus.req_vld = 4'b0010;
    tick();
    bus.req_vld = '0;
    push_rsp(1, 700);
    bus.dma_rd_rsp_vld = 1'b1;
    bus.dma_rd_rsp_pd = RSP_W'(700);
    @(negedge clk);
    chk("s6_post_route", bus.rsp_vld, 4'b0010);
    tick();
    bus.dma_rd_rsp_vld = 1'b0;
    @(negedge clk);
    chk("s6_post_idle", arb_idle, 1);
    chk("s6_post_err", arb_err, 0);

    tick();
    @(negedge clk);
    chk("req_queue_drained", req_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nv_nvdla_sdp_rdma_rd_arb.md
# nv_nvdla_sdp_rdma_rd_arb

Round-robin read arbiter that shares one SDP DMA read channel (request 47 b, response 65 b) among NUM_REQ SDP read engines (MRDMA/BRDMA/NRDMA/ERDMA). It sits between the per-engine request generators / latency FIFOs and the single dmaif instance. An in-order ID FIFO routes each response beat back to the engine that issued the request. Request and response paths are combinational pass-through; all state is in the grant pointer, the stall lock, the ID FIFO and the beat counter.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ID_DEPTH, 16: outstanding-request FIFO depth (power of 2).
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  asynchronous, active-low reset.
- req_vld  in  NUM_REQ  per-engine request valid.
- req_rdy  out  NUM_REQ  per-engine request ready.
- req_pd  in  NUM_REQ*47  per-engine request; [46:32]=size (beats-1), [31:0]=addr; engine i at [47*i+:47].
- dma_rd_req_vld / dma_rd_req_rdy / dma_rd_req_pd  out / in / out  1/1/47  merged request to dmaif.
- dma_rd_rsp_vld / dma_rd_rsp_rdy / dma_rd_rsp_pd  in / out / in  1/1/65  in-order response from dmaif.
- rsp_vld  out  NUM_REQ  per-engine response valid.
- rsp_rdy  in  NUM_REQ  per-engine response ready.
- rsp_pd  out  65  shared response payload (= dma_rd_rsp_pd).
- arb_idle  out  1  ID FIFO empty and no request pending.
- arb_err  out  1  sticky: response beat arrived with ID FIFO empty; cleared only by reset.

## Operation
- Grant: round-robin from rr_ptr; first i in rr_ptr, rr_ptr+1, ... (mod NUM_REQ) with req_vld[i].
- Stall lock: if dma_rd_req_vld & !dma_rd_req_rdy, grant is registered into lock_id/locked; while locked, grant = lock_id regardless of other req_vld. Lock clears on acceptance.
- dma_rd_req_vld = (any req_vld) & !id_full; dma_rd_req_pd = req_pd[grant]; req_rdy[grant] = dma_rd_req_rdy & !id_full; all other req_rdy = 0.
- On accept: push {grant, size} into ID FIFO; rr_ptr <= grant+1 (mod NUM_REQ).
- Response: head entry {hid, hsize}. rsp_vld[hid] = dma_rd_rsp_vld & !id_empty; others 0. dma_rd_rsp_rdy = rsp_rdy[hid] & !id_empty.
- Beat counter (15 b): +1 per accepted beat; when beat_cnt == hsize on accepted beat, pop FIFO and reset beat_cnt to 0.
- dma_rd_rsp_vld while id_empty: rdy held 0, arb_err set.
- Push gated by registered id_full; push/pop in same cycle at full not possible (push blocked). Push/pop same cycle when neither full nor empty: count unchanged.
- arb_idle = id_empty & !(any req_vld).

## Timing
- Reset: rr_ptr=0, locked=0, lock_id=0, ID FIFO empty, beat_cnt=0, arb_err=0; all req_rdy, rsp_vld, dma_rd_req_vld = 0; dma_rd_rsp_rdy=0; arb_idle=1.
- Request path: 0-cycle combinational req_vld->dma_rd_req_vld, dma_rd_req_rdy->req_rdy.
- Response path: 0-cycle combinational; earliest routable beat is the cycle after its request is accepted (no FIFO bypass).
- Valid/payload of a stalled dma_rd_req held stable (lock guarantees pd source does not change).
- Fairness: with all requesters continuously valid and rdy=1, grants rotate 0,1,..,NUM_REQ-1, one per cycle.
- Reset mid-burst: FIFO, counter and lock cleared immediately (async); in-flight responses are the system's responsibility.

## Structure
- Shared package: request/response widths (47, 65), size field bounds [46:32], NUM_REQ/ID_DEPTH defaults, ID width = clog2(NUM_REQ).
- One sub-module: nv_nvdla_sdp_rdma_rd_arb_idfifo (flop-based sync FIFO, width clog2(NUM_REQ)+15, depth ID_DEPTH, full/empty flags registered).

## Test plan
- All 4 engines valid continuously, size=0, rdy=1 -> grants 0,1,2,3,0,...; each response beat appears only on rsp_vld of matching engine.
- Engine 2 granted, dma_rd_req_rdy=0 for 5 cycles while engine 0 raises valid -> pd stays engine 2's, req_rdy[0]=0; engine 2 accepted on cycle 6, then engine 3 (if valid) else engine 0.
- 16 requests accepted, no responses -> id_full, dma_rd_req_vld=0, all req_rdy=0; one full response burst frees slot, next cycle request accepted.
- Engine 1 size=3 then engine 0 size=0; rsp_rdy[1] deasserted on beat 2 -> dma_rd_rsp_rdy=0, beat held; 4 beats to engine 1, then 1 beat to engine 0, FIFO empty, arb_idle=1.
- dma_rd_rsp_vld=1 after reset with no requests -> dma_rd_rsp_rdy=0, arb_err=1 next cycle and stays 1 until rstn low.
- Assert rstn low during a 4-beat burst after beat 2 -> all outputs at reset values, beat_cnt=0, FIFO empty.
